// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle between the 5-stage pipeline datapath and its hazard controller.
//   master : the datapath side; drives the stage instructions and the
//            branch / memory / interrupt status, receives the enables.
//   slave  : the hazard controller.
// Signals
//   dec_ir, exe_ir, mem_ir : instructions in decode / execute / memory
//   br_taken               : branch, JAL or JALR in EXE redirects the PC
//   mem_ready              : data memory finished the access for mem_ir
//   int_req                : level interrupt request, already CSR-masked
//   pc_en .. wb_ir_en      : stage-register load enables
//   dec_flush, exe_flush   : load a NOP into DEC_IR / EXE_IR
//   int_taken              : one-cycle pulse, PC loads the mtvec vector
//   stall_cnt              : saturating count of cycles with pc_en = 0
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] dec_ir;
    logic [DATA_W-1:0] exe_ir;
    logic [DATA_W-1:0] mem_ir;
    logic              br_taken;
    logic              mem_ready;
    logic              int_req;
    logic              pc_en;
    logic              dec_ir_en;
    logic              exe_ir_en;
    logic              mem_ir_en;
    logic              wb_ir_en;
    logic              dec_flush;
    logic              exe_flush;
    logic              int_taken;
    logic [15:0]       stall_cnt;

    modport master (
        output dec_ir, exe_ir, mem_ir, br_taken, mem_ready, int_req,
        input  pc_en, dec_ir_en, exe_ir_en, mem_ir_en, wb_ir_en,
        input  dec_flush, exe_flush, int_taken, stall_cnt
    );

    modport slave (
        input  dec_ir, exe_ir, mem_ir, br_taken, mem_ready, int_req,
        output pc_en, dec_ir_en, exe_ir_en, mem_ir_en, wb_ir_en,
        output dec_flush, exe_flush, int_taken, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Stall / flush / interrupt sequencing for a 5-stage RV32 pipeline.
// Ports
//   clk   : pipeline clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   hz    : pipeline_hazard_ctrl_if.slave (stage instructions and status in,
//           stage enables, flushes, interrupt pulse and stall counter out)
// Behaviour summary
//   - an outstanding load/store in MEM freezes every stage and outranks all
//     other conditions; the controller resumes in the state it left
//   - a load-use hazard inserts a single bubble into EXE
//   - a taken branch flushes DEC and EXE
//   - an interrupt drains the pipe for three cycles with fetch held, then
//     pulses int_taken for one cycle while the PC loads the vector
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  hz
);
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_INT_DRAIN,
        ST_INT_TAKE
    } state_t;

    state_t      state_q, state_d;
    state_t      ret_q, ret_d;
    state_t      eff_state;
    logic [1:0]  drain_q, drain_d;
    logic [15:0] stall_q;

    logic pc_en, dec_ir_en, exe_ir_en, mem_ir_en, wb_ir_en;
    logic dec_flush, exe_flush, int_taken;
    logic mem_stall, load_use;
    logic dec_uses_rs1, dec_uses_rs2;
    logic unused_bits;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Only the opcode and register fields take part in hazard detection.
    assign unused_bits = ^{hz.dec_ir[31:25], hz.dec_ir[14:7],
                           hz.exe_ir[31:12], hz.mem_ir[31:7]};

    assign mem_stall = ((hz.mem_ir[6:0] == OPC_LOAD) || (hz.mem_ir[6:0] == OPC_STORE))
                       && !hz.mem_ready;

    assign dec_uses_rs1 = !((hz.dec_ir[6:0] == OPC_LUI) || (hz.dec_ir[6:0] == OPC_AUIPC) ||
                            (hz.dec_ir[6:0] == OPC_JAL));
    assign dec_uses_rs2 = (hz.dec_ir[6:0] == OPC_OP) || (hz.dec_ir[6:0] == OPC_STORE) ||
                          (hz.dec_ir[6:0] == OPC_BRANCH);

    assign load_use = (hz.exe_ir[6:0] == OPC_LOAD) && (hz.exe_ir[11:7] != 5'd0) &&
                      ((dec_uses_rs1 && (hz.exe_ir[11:7] == hz.dec_ir[19:15])) ||
                       (dec_uses_rs2 && (hz.exe_ir[11:7] == hz.dec_ir[24:20])));

    // While parked in MEM_WAIT the cycle that releases it acts as the saved state.
    assign eff_state = (state_q == ST_MEM_WAIT) ? ret_q : state_q;

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        drain_d   = drain_q;
        pc_en     = 1'b0;
        dec_ir_en = 1'b0;
        exe_ir_en = 1'b0;
        mem_ir_en = 1'b0;
        wb_ir_en  = 1'b0;
        dec_flush = 1'b0;
        exe_flush = 1'b0;
        int_taken = 1'b0;

        if (!rst_n) begin
            dec_flush = 1'b1;
            exe_flush = 1'b1;
        end else if (mem_stall) begin
            state_d = ST_MEM_WAIT;
            ret_d   = eff_state;
        end else begin
            state_d   = eff_state;
            dec_ir_en = 1'b1;
            exe_ir_en = 1'b1;
            mem_ir_en = 1'b1;
            wb_ir_en  = 1'b1;
            unique case (eff_state)
                ST_RUN: begin
                    pc_en = 1'b1;
                    if (hz.br_taken) begin
                        dec_flush = 1'b1;
                        exe_flush = 1'b1;
                    end else if (!hz.int_req && load_use) begin
                        // Hold PC and DEC, push a bubble into EXE.
                        pc_en     = 1'b0;
                        dec_ir_en = 1'b0;
                        exe_flush = 1'b1;
                    end
                    if (hz.int_req) begin
                        state_d = ST_INT_DRAIN;
                        drain_d = 2'd3;
                    end
                end
                ST_INT_DRAIN: begin
                    // Fetch held, NOPs fed into DEC while older work retires.
                    dec_flush = 1'b1;
                    exe_flush = hz.br_taken;
                    if (drain_q <= 2'd1) begin
                        state_d = ST_INT_TAKE;
                        drain_d = 2'd0;
                    end else begin
                        drain_d = drain_q - 2'd1;
                    end
                end
                ST_INT_TAKE: begin
                    pc_en     = 1'b1;
                    dec_flush = 1'b1;
                    int_taken = 1'b1;
                    state_d   = ST_RUN;
                end
                default: begin
                    pc_en   = 1'b1;
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            ret_q   <= ST_RUN;
            drain_q <= 2'd0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            drain_q <= drain_d;
            if (!pc_en) begin
                stall_q <= sat_inc(stall_q);
            end
        end
    end

    assign hz.pc_en     = pc_en;
    assign hz.dec_ir_en = dec_ir_en;
    assign hz.exe_ir_en = exe_ir_en;
    assign hz.mem_ir_en = mem_ir_en;
    assign hz.wb_ir_en  = wb_ir_en;
    assign hz.dec_flush = dec_flush;
    assign hz.exe_flush = exe_flush;
    assign hz.int_taken = int_taken;
    assign hz.stall_cnt = stall_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Testbench for pipeline_hazard_ctrl: vector table, directed multi-cycle
// sequences, randomized traffic against a reference model, and counter
// saturation.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;
    // Output vector order: {pc_en, dec_ir_en, exe_ir_en, mem_ir_en, wb_ir_en,
    //                       dec_flush, exe_flush, int_taken}
    localparam logic [7:0] O_RUN = 8'b11111_00_0;
    localparam logic [7:0] O_LU  = 8'b00111_01_0;
    localparam logic [7:0] O_BR  = 8'b11111_11_0;
    localparam logic [7:0] O_MW  = 8'b00000_00_0;
    localparam logic [7:0] O_DR  = 8'b01111_10_0;
    localparam logic [7:0] O_DRB = 8'b01111_11_0;
    localparam logic [7:0] O_TK  = 8'b11111_10_1;
    localparam logic [7:0] O_RST = 8'b00000_11_0;

    localparam logic [31:0] NOP       = 32'h00000013;
    localparam logic [31:0] LW_X5     = 32'h0000A283; // lw   x5,0(x1)
    localparam logic [31:0] LW_X0     = 32'h0000A003; // lw   x0,0(x1)
    localparam logic [31:0] ADD_RS1   = 32'h00728333; // add  x6,x5,x7
    localparam logic [31:0] ADD_X0    = 32'h00700333; // add  x6,x0,x7
    localparam logic [31:0] ADD_RS2   = 32'h00538333; // add  x6,x7,x5
    localparam logic [31:0] ADDI_IMM5 = 32'h00538313; // addi x6,x7,5
    localparam logic [31:0] ADDI_RS1  = 32'h00128313; // addi x6,x5,1
    localparam logic [31:0] LUI_F5    = 32'h00028337; // lui, bits 19:15 = 5
    localparam logic [31:0] SW_X5     = 32'h00512023; // sw   x5,0(x2)
    localparam logic [31:0] BEQ_X5    = 32'h00508063; // beq  x1,x5
    localparam logic [31:0] JAL_F5    = 32'h0002836F; // jal, bits 19:15 = 5
    localparam logic [31:0] ADD_RD5   = 32'h002082B3; // add  x5,x1,x2

    logic clk;
    logic rst_n;

    pipeline_hazard_ctrl_if #(.DATA_W(32)) bus ();

    pipeline_hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;
    int exp_stall;

    typedef struct {
        logic [31:0] dec;
        logic [31:0] exe;
        logic [31:0] mem;
        logic        br;
        logic        rdy;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl[$];

    // Reference model state for the randomized phase.
    int drain_left;
    bit take_now;

    function automatic logic [7:0] get_out();
        return {bus.pc_en, bus.dec_ir_en, bus.exe_ir_en, bus.mem_ir_en, bus.wb_ir_en,
                bus.dec_flush, bus.exe_flush, bus.int_taken};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] dec, input logic [31:0] exe, input logic [31:0] mem,
                          input logic br, input logic rdy, input logic intr);
        bus.dec_ir    = dec;
        bus.exe_ir    = exe;
        bus.mem_ir    = mem;
        bus.br_taken  = br;
        bus.mem_ready = rdy;
        bus.int_req   = intr;
    endtask

    // Check outputs and counter mid-cycle, then step across the rising edge.
    task automatic cycle(input string name, input logic [7:0] exp);
        @(negedge clk);
        chk($sformatf("%s/out", name), {24'd0, get_out()}, {24'd0, exp});
        chk($sformatf("%s/stall_cnt", name), {16'd0, bus.stall_cnt}, exp_stall);
        @(posedge clk);
        if (rst_n && !exp[7]) begin
            exp_stall = (exp_stall >= 65535) ? 65535 : exp_stall + 1;
        end
        #1;
    endtask

    function automatic bit ref_load_use(input logic [31:0] d, input logic [31:0] e);
        logic [6:0] dop;
        logic [4:0] rd;
        bit         rs1_read;
        bit         rs2_read;
        dop = d[6:0];
        rd  = e[11:7];
        rs1_read = !(dop == 7'b0110111 || dop == 7'b0010111 || dop == 7'b1101111);
        rs2_read = (dop == 7'b0110011 || dop == 7'b0100011 || dop == 7'b1100011);
        if (e[6:0] != 7'b0000011 || rd == 5'd0) return 1'b0;
        return (rs1_read && rd == d[19:15]) || (rs2_read && rd == d[24:20]);
    endfunction

    function automatic bit ref_mem_busy(input logic [31:0] m, input logic rdy);
        return (m[6:0] == 7'b0000011 || m[6:0] == 7'b0100011) && !rdy;
    endfunction

    // Expected outputs for the current inputs; advances the model one cycle.
    function automatic logic [7:0] ref_step(input logic [31:0] d, input logic [31:0] e,
                                            input logic [31:0] m, input logic br,
                                            input logic rdy, input logic intr);
        logic [7:0] r;
        if (ref_mem_busy(m, rdy)) begin
            r = O_MW;
        end else if (take_now) begin
            r = O_TK;
            take_now = 1'b0;
        end else if (drain_left > 0) begin
            r = br ? O_DRB : O_DR;
            drain_left--;
            if (drain_left == 0) take_now = 1'b1;
        end else begin
            if (br)                                r = O_BR;
            else if (!intr && ref_load_use(d, e)) r = O_LU;
            else                                   r = O_RUN;
            if (intr) drain_left = 3;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_instr(input bit want_load);
        logic [6:0] opc;
        case ($urandom_range(0, 8))
            0:       opc = 7'b0000011;
            1:       opc = 7'b0100011;
            2:       opc = 7'b0110011;
            3:       opc = 7'b0010011;
            4:       opc = 7'b1100011;
            5:       opc = 7'b0110111;
            6:       opc = 7'b0010111;
            7:       opc = 7'b1101111;
            default: opc = 7'b1100111;
        endcase
        if (want_load) opc = 7'b0000011;
        return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), opc};
    endfunction

    task automatic add_vec(input logic [31:0] dec, input logic [31:0] exe, input logic [31:0] mem,
                           input logic br, input logic rdy, input logic [7:0] exp);
        vec_t v;
        v.dec = dec; v.exe = exe; v.mem = mem; v.br = br; v.rdy = rdy; v.exp = exp;
        tbl.push_back(v);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, e, m;
        logic        br, rdy, intr;
        logic [7:0]  ex;

        n_checks  = 0;
        n_fail    = 0;
        exp_stall = 0;
        drain_left = 0;
        take_now   = 1'b0;

        // Reset state and first cycle after release.
        rst_n = 1'b0;
        set_in(NOP, NOP, NOP, 1'b0, 1'b1, 1'b0);
        #1;
        cycle("reset0", O_RST);
        cycle("reset1", O_RST);
        rst_n = 1'b1;
        cycle("post_reset", O_RUN);

        // Single-cycle decisions from RUN.
        add_vec(NOP,       NOP,     NOP,   1'b0, 1'b1, O_RUN);
        add_vec(ADD_RS1,   LW_X5,   NOP,   1'b0, 1'b1, O_LU);
        add_vec(ADD_X0,    LW_X0,   NOP,   1'b0, 1'b1, O_RUN);
        add_vec(ADD_RS2,   LW_X5,   NOP,   1'b0, 1'b1, O_LU);
        add_vec(ADDI_IMM5, LW_X5,   NOP,   1'b0, 1'b1, O_RUN);
        add_vec(ADDI_RS1,  LW_X5,   NOP,   1'b0, 1'b1, O_LU);
        add_vec(LUI_F5,    LW_X5,   NOP,   1'b0, 1'b1, O_RUN);
        add_vec(SW_X5,     LW_X5,   NOP,   1'b0, 1'b1, O_LU);
        add_vec(BEQ_X5,    LW_X5,   NOP,   1'b0, 1'b1, O_LU);
        add_vec(JAL_F5,    LW_X5,   NOP,   1'b0, 1'b1, O_RUN);
        add_vec(ADD_RS1,   ADD_RD5, NOP,   1'b0, 1'b1, O_RUN);
        add_vec(ADD_RS1,   LW_X5,   NOP,   1'b1, 1'b1, O_BR);
        add_vec(NOP,       NOP,     NOP,   1'b1, 1'b1, O_BR);
        add_vec(NOP,       NOP,     SW_X5, 1'b0, 1'b0, O_MW);
        add_vec(NOP,       NOP,     SW_X5, 1'b0, 1'b1, O_RUN);
        add_vec(ADD_RS1,   LW_X5,   LW_X5, 1'b1, 1'b0, O_MW);
        add_vec(NOP,       NOP,   ADD_RD5, 1'b0, 1'b0, O_RUN);
        add_vec(NOP,       NOP,     NOP,   1'b0, 1'b1, O_RUN);
        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].dec, tbl[i].exe, tbl[i].mem, tbl[i].br, tbl[i].rdy, 1'b0);
            cycle($sformatf("tbl%0d", i), tbl[i].exp);
        end

        // Store held in MEM for four cycles.
        set_in(NOP, NOP, SW_X5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle($sformatf("memwait%0d", i), O_MW);
        set_in(NOP, NOP, SW_X5, 1'b0, 1'b1, 1'b0);
        cycle("memwait_exit", O_RUN);

        // One-cycle interrupt request coinciding with a load-use hazard.
        set_in(ADD_RS1, LW_X5, NOP, 1'b0, 1'b1, 1'b1);
        cycle("int_req", O_RUN);
        set_in(NOP, NOP, NOP, 1'b0, 1'b1, 1'b0);
        cycle("int_drain0", O_DR);
        set_in(NOP, NOP, NOP, 1'b1, 1'b1, 1'b0);
        cycle("int_drain1_br", O_DRB);
        set_in(NOP, NOP, NOP, 1'b0, 1'b1, 1'b0);
        cycle("int_drain2", O_DR);
        cycle("int_take", O_TK);
        cycle("int_back_run", O_RUN);

        // Memory wait inserted in the middle of the drain.
        set_in(NOP, NOP, NOP, 1'b0, 1'b1, 1'b1);
        cycle("int2_req", O_RUN);
        set_in(NOP, NOP, NOP, 1'b0, 1'b1, 1'b0);
        cycle("int2_drain0", O_DR);
        set_in(NOP, NOP, LW_X5, 1'b0, 1'b0, 1'b0);
        cycle("int2_wait0", O_MW);
        cycle("int2_wait1", O_MW);
        set_in(NOP, NOP, LW_X5, 1'b0, 1'b1, 1'b0);
        cycle("int2_drain1", O_DR);
        set_in(NOP, NOP, NOP, 1'b0, 1'b1, 1'b0);
        cycle("int2_drain2", O_DR);
        cycle("int2_take", O_TK);
        cycle("int2_back_run", O_RUN);

        // Reset during the drain aborts the interrupt.
        set_in(NOP, NOP, NOP, 1'b0, 1'b1, 1'b1);
        cycle("int3_req", O_RUN);
        set_in(NOP, NOP, NOP, 1'b0, 1'b1, 1'b0);
        cycle("int3_drain0", O_DR);
        rst_n = 1'b0;
        exp_stall = 0;
        cycle("int3_reset", O_RST);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cycle($sformatf("int3_after%0d", i), O_RUN);

        // Randomized traffic against the reference model.
        drain_left = 0;
        take_now   = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            e    = rand_instr($urandom_range(0, 1) == 0);
            d    = rand_instr(1'b0);
            m    = ($urandom_range(0, 2) == 0) ? LW_X5 : rand_instr(1'b0);
            rdy  = ($urandom_range(0, 4) != 0);
            br   = ($urandom_range(0, 9) == 0);
            intr = ($urandom_range(0, 19) == 0);
            set_in(d, e, m, br, rdy, intr);
            ex = ref_step(d, e, m, br, rdy, intr);
            cycle($sformatf("rnd%0d", i), ex);
        end

        // Counter saturation over a long memory wait.
        set_in(NOP, NOP, SW_X5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) @(posedge clk);
        #1;
        exp_stall = (exp_stall + 70000 > 65535) ? 65535 : exp_stall + 70000;
        cycle("sat_hold", O_MW);
        cycle("sat_hold2", O_MW);
        set_in(NOP, NOP, SW_X5, 1'b0, 1'b1, 1'b0);
        cycle("sat_release", O_RUN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; all state SHALL update on the rising edge of CLK.
REQ-002 CLK  in  1  pipeline clock.
REQ-003 RST_N  in  1  asynchronous active-low reset.
REQ-004 DEC_IR  in  32  instruction in the decode stage.
REQ-005 EXE_IR  in  32  instruction in the execute stage.
REQ-006 MEM_IR  in  32  instruction in the memory stage.
REQ-007 BR_TAKEN  in  1  branch, JAL or JALR in EXE redirects the PC this cycle.
REQ-008 MEM_READY  in  1  data memory has completed the access for MEM_IR.
REQ-009 INT_REQ  in  1  level interrupt request, pre-masked by the CSR enable.
REQ-010 PC_EN, DEC_IR_EN, EXE_IR_EN, MEM_IR_EN, WB_IR_EN  out  1 each  stage-register load enables.
REQ-011 DEC_FLUSH, EXE_FLUSH  out  1 each  load a NOP (32'h00000013) into DEC_IR or EXE_IR instead of the upstream value.
REQ-012 INT_TAKEN  out  1  one-cycle pulse: PC loads the mtvec vector.
REQ-013 STALL_CNT  out  16  count of cycles in which PC_EN=0.

Function
REQ-014 SHALL implement an FSM with states RUN, MEM_WAIT, INT_DRAIN and INT_TAKE.
REQ-015 MEM_WAIT SHALL be active when MEM_IR opcode is LOAD (0000011) or STORE (0100011) and MEM_READY=0.
REQ-016 While MEM_WAIT is active, all five enables SHALL be 0, both flushes SHALL be 0, and the state SHALL hold.
REQ-017 MEM_WAIT SHALL take priority over every other condition.
REQ-018 MEM_WAIT SHALL exit to the saved return state (RUN or INT_DRAIN) in the first cycle MEM_READY=1, and that cycle SHALL behave as the return state.
REQ-019 In RUN with no hazard, all enables SHALL be 1 and both flushes SHALL be 0.
REQ-020 A load-use hazard exists when all of the following hold:
- EXE_IR opcode is LOAD;
- EXE rd (bits 11:7) is nonzero;
- EXE rd equals DEC rs1 (bits 19:15) when the DEC opcode reads rs1 (all opcodes except LUI, AUIPC, JAL), or equals DEC rs2 (bits 24:20) when the DEC opcode is OP, STORE or BRANCH.
REQ-021 On a load-use hazard in RUN, PC_EN and DEC_IR_EN SHALL be 0, EXE_FLUSH SHALL be 1, and the remaining enables SHALL be 1, giving exactly a one-cycle bubble.
REQ-022 On BR_TAKEN in RUN, PC_EN=1, DEC_FLUSH=1 and EXE_FLUSH=1; BR_TAKEN SHALL override a simultaneous load-use hazard.
REQ-023 On INT_REQ=1 in RUN with no MEM_WAIT, the FSM SHALL enter INT_DRAIN on the next edge, load a 2-bit drain counter with 3, and suppress any load-use stall in that cycle.
REQ-024 In INT_DRAIN:
- PC_EN=0 and DEC_FLUSH=1;
- the downstream enables SHALL be 1;
- the counter SHALL decrement each non-MEM_WAIT cycle;
- the FSM SHALL go to INT_TAKE when the counter is 0.
REQ-025 A BR_TAKEN during INT_DRAIN SHALL assert EXE_FLUSH=1 and SHALL NOT change state.
REQ-026 INT_TAKE SHALL last exactly one cycle, with INT_TAKEN=1, PC_EN=1, DEC_FLUSH=1 and all other enables 1, and SHALL return to RUN.
REQ-027 INT_REQ deasserting after INT_DRAIN is entered SHALL NOT abort the sequence.
REQ-028 STALL_CNT SHALL increment by 1 in every cycle with PC_EN=0 and saturate at 16'hFFFF.
REQ-029 The FSM SHALL never produce DEC_IR_EN=1 together with DEC_FLUSH=0 in a cycle where PC_EN=0, except in MEM_WAIT, where all enables are 0.

Reset
REQ-030 While RST_N=0:
- state=RUN;
- drain counter=0;
- STALL_CNT=0;
- INT_TAKEN=0;
- PC_EN and all IR enables=0;
- DEC_FLUSH=1 and EXE_FLUSH=1.
REQ-031 Reset asserted mid-sequence in any state SHALL immediately force the reset values without completing the sequence.
REQ-032 In the first cycle after RST_N rises, the block SHALL be in RUN with outputs per REQ-019.

Verification
REQ-033 Load-use: EXE_IR=LW x5,0(x1) with DEC_IR=ADD x6,x5,x7 -> one cycle with PC_EN=0, DEC_IR_EN=0, EXE_FLUSH=1, STALL_CNT +1; with rd=x0 instead -> no stall.
REQ-034 Branch override: load-use hazard and BR_TAKEN=1 in the same cycle -> PC_EN=1, DEC_FLUSH=1, EXE_FLUSH=1, no stall.
REQ-035 Memory wait: MEM_IR=SW with MEM_READY held 0 for 4 cycles -> all enables 0 for 4 cycles, STALL_CNT +4, RUN resumes on the cycle MEM_READY=1.
REQ-036 Interrupt: a 1-cycle INT_REQ in RUN -> 3 cycles of INT_DRAIN, then INT_TAKEN=1 for exactly 1 cycle, then RUN; when MEM_READY=0 is inserted mid-drain, the drain extends by the wait length.
REQ-037 Reset in INT_DRAIN (RST_N low for 1 cycle) -> INT_TAKEN never pulses, STALL_CNT=0, RUN after release.
REQ-038 Saturation: force 70000 stall cycles -> STALL_CNT=16'hFFFF, no wrap.
